// File: rtl/approx_mul_error_sweeper.sv
// Exhaustive error sweeper for an approximate multiplier: issues every operand pair,
// scores the returned product against the exact one and accumulates error statistics.
module approx_mul_error_sweeper #(
   parameter int unsigned A_W          = 2,
   parameter int unsigned DUT_LAT      = 0,
   parameter bit          STOP_ON_FAIL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [2*A_W-1:0]   et,
   output logic [2*A_W-1:0]   stim,
   input  logic [2*A_W-1:0]   dut_out,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*A_W-1:0]   max_err,
   output logic [4*A_W-1:0]   sum_err,
   output logic [2*A_W:0]     fail_cnt,
   output logic [2*A_W-1:0]   first_fail
);

   localparam int unsigned SW    = 2 * A_W;
   localparam int unsigned EW    = SW + 1;
   localparam int unsigned XW    = 4 * A_W;
   localparam int unsigned CW    = SW + 1;
   localparam int unsigned DEPTH = DUT_LAT + 1;
   localparam int unsigned DCW   = $clog2(DEPTH + 1);
   localparam logic [SW-1:0] STIM_LAST = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [SW-1:0]    pstim_q [DEPTH];
   logic [SW-1:0]    pstim_d [DEPTH];
   logic [DCW-1:0]   drain_q, drain_d;
   logic [SW-1:0]    et_q, et_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [SW-1:0]    max_q, max_d;
   logic [XW-1:0]    sum_q, sum_d;
   logic [CW-1:0]    fcnt_q, fcnt_d;
   logic [SW-1:0]    ff_q, ff_d;

   logic             sc_vld;
   logic [SW-1:0]    sc_stim;
   logic [SW-1:0]    prod;
   logic [EW-1:0]    diff;
   logic [EW-1:0]    err;
   logic             sc_fail;
   logic             sof_hit;

   // Scoring datapath: the last delay-line stage lines up with dut_out.
   always_comb begin
      sc_vld  = vld_q[DEPTH-1];
      sc_stim = pstim_q[DEPTH-1];
      prod    = SW'(sc_stim[A_W-1:0]) * SW'(sc_stim[SW-1:A_W]);
      diff    = {1'b0, dut_out} - {1'b0, prod};
      err     = diff[EW-1] ? (EW'(0) - diff) : diff;
      sc_fail = sc_vld && (err > EW'(et_q));
      sof_hit = STOP_ON_FAIL && sc_fail;
   end

   always_comb begin
      state_d = state_q;
      vld_d   = '0;
      pstim_d = pstim_q;
      drain_d = drain_q;
      et_d    = et_q;
      max_d   = max_q;
      sum_d   = sum_q;
      fcnt_d  = fcnt_q;
      ff_d    = ff_q;
      pass_d  = pass_q;

      for (int i = 1; i < DEPTH; i++) begin
         vld_d[i]   = vld_q[i-1];
         pstim_d[i] = pstim_q[i-1];
      end

      if (sc_vld) begin
         if (err > EW'(max_q)) max_d = err[SW-1:0];
         sum_d  = sum_q + XW'(err);
         fcnt_d = fcnt_q + CW'(sc_fail);
         if (sc_fail && (ff_q == '1)) ff_d = sc_stim;
      end

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d    = S_RUN;
               et_d       = et;
               pstim_d[0] = '0;
               vld_d[0]   = 1'b1;
               max_d      = '0;
               sum_d      = '0;
               fcnt_d     = '0;
               ff_d       = '1;
               pass_d     = 1'b0;
            end
         end
         S_RUN: begin
            // Holding at the last vector keeps stim from wrapping to 0.
            if (pstim_q[0] == STIM_LAST) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end else begin
               pstim_d[0] = pstim_q[0] + SW'(1);
               vld_d[0]   = 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == DCW'(DUT_LAT)) state_d = S_DONE;
            else                          drain_d = drain_q + DCW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // First failure: stop issuing and drop everything still in flight.
      if (sof_hit) begin
         vld_d      = '0;
         pstim_d[0] = pstim_q[0];
         if (state_q == S_RUN) begin
            state_d = S_DRAIN;
            drain_d = '0;
         end
      end

      if (abort && ((state_q == S_RUN) || (state_q == S_DRAIN))) begin
         state_d = S_IDLE;
         vld_d   = '0;
         pass_d  = 1'b0;
      end

      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
      if (state_d == S_DONE) pass_d = (max_d <= et_q) && (fcnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         vld_q   <= '0;
         for (int i = 0; i < DEPTH; i++) pstim_q[i] <= '0;
         drain_q <= '0;
         et_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         max_q   <= '0;
         sum_q   <= '0;
         fcnt_q  <= '0;
         ff_q    <= '1;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         pstim_q <= pstim_d;
         drain_q <= drain_d;
         et_q    <= et_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         max_q   <= max_d;
         sum_q   <= sum_d;
         fcnt_q  <= fcnt_d;
         ff_q    <= ff_d;
      end
   end

   assign stim       = pstim_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign max_err    = max_q;
   assign sum_err    = sum_q;
   assign fail_cnt   = fcnt_q;
   assign first_fail = ff_q;

endmodule

// File: tb/tb_approx_mul_error_sweeper.sv
// Bench for approx_mul_error_sweeper: combinational, 2-stage and stop-on-fail instances
// driven by a table of sweeps plus hand-written reset/abort sequences.
module tb_approx_mul_error_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_s [3];
   logic       abort_s [3];
   logic [3:0] et_s    [3];
   logic [1:0] mode_s  [3];
   logic [3:0] stim_s  [3];
   logic [3:0] max_s   [3];
   logic [3:0] ff_s    [3];
   logic       busy_s  [3];
   logic       done_s  [3];
   logic       pass_s  [3];
   logic [7:0] sum_s   [3];
   logic [4:0] fcnt_s  [3];
   logic [3:0] dut0, dut1, dut2, r1, r2;

   // DUT stand-in: 0 = exact product, 1 = tied to zero, 2 = tied to all-ones.
   function automatic logic [3:0] model(input logic [1:0] m, input logic [3:0] s);
      case (m)
         2'd0:    return 4'(s[1:0]) * 4'(s[3:2]);
         2'd1:    return 4'h0;
         default: return 4'hF;
      endcase
   endfunction

   assign dut0 = model(mode_s[0], stim_s[0]);
   assign dut2 = model(mode_s[2], stim_s[2]);
   always @(posedge clk) begin
      r1 <= model(mode_s[1], stim_s[1]);
      r2 <= r1;
   end
   assign dut1 = r2;

   approx_mul_error_sweeper #(.A_W(2), .DUT_LAT(0), .STOP_ON_FAIL(1'b0)) u_lat0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .et(et_s[0]),
      .stim(stim_s[0]), .dut_out(dut0), .busy(busy_s[0]), .done(done_s[0]),
      .pass(pass_s[0]), .max_err(max_s[0]), .sum_err(sum_s[0]),
      .fail_cnt(fcnt_s[0]), .first_fail(ff_s[0]));

   approx_mul_error_sweeper #(.A_W(2), .DUT_LAT(2), .STOP_ON_FAIL(1'b0)) u_lat2 (
      .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .et(et_s[1]),
      .stim(stim_s[1]), .dut_out(dut1), .busy(busy_s[1]), .done(done_s[1]),
      .pass(pass_s[1]), .max_err(max_s[1]), .sum_err(sum_s[1]),
      .fail_cnt(fcnt_s[1]), .first_fail(ff_s[1]));

   approx_mul_error_sweeper #(.A_W(2), .DUT_LAT(0), .STOP_ON_FAIL(1'b1)) u_sof (
      .clk(clk), .rst(rst), .start(start_s[2]), .abort(abort_s[2]), .et(et_s[2]),
      .stim(stim_s[2]), .dut_out(dut2), .busy(busy_s[2]), .done(done_s[2]),
      .pass(pass_s[2]), .max_err(max_s[2]), .sum_err(sum_s[2]),
      .fail_cnt(fcnt_s[2]), .first_fail(ff_s[2]));

   typedef struct {
      int         inst;
      logic [1:0] mode;
      logic [3:0] et;
      int         lat;
      logic       pass;
      logic [3:0] maxe;
      logic [7:0] sume;
      logic [4:0] fcnt;
      logic [3:0] ff;
      string      nm;
   } sweep_t;

   sweep_t tbl [8];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic wait_stim(input int k, input logic [3:0] val);
      bit found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         if (stim_s[k] == val) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk($sformatf("reach_stim_%0d", val), 32'(found), 32'd1);
   endtask

   task automatic kick(input int k, input logic [1:0] m, input logic [3:0] e);
      mode_s[k] = m;
      et_s[k]   = e;
      @(negedge clk);
      start_s[k] = 1'b1;
      @(posedge clk); #1;
      start_s[k] = 1'b0;
   endtask

   task automatic run_sweep(input sweep_t v);
      int k      = v.inst;
      int lat    = -1;
      int busy_n = 0;
      kick(k, v.mode, v.et);
      // The threshold is latched at start; disturbing it must not matter.
      et_s[k] = ~v.et;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (done_s[k])      lat = n;
         else if (busy_s[k]) busy_n++;
      end
      chk({v.nm, "_done_latency"}, 32'(lat), 32'(v.lat));
      chk({v.nm, "_busy_cycles"}, 32'(busy_n), 32'(v.lat - 1));
      chk({v.nm, "_busy_at_done"}, 32'(busy_s[k]), 32'd0);
      chk({v.nm, "_pass"}, 32'(pass_s[k]), 32'(v.pass));
      chk({v.nm, "_max_err"}, 32'(max_s[k]), 32'(v.maxe));
      chk({v.nm, "_sum_err"}, 32'(sum_s[k]), 32'(v.sume));
      chk({v.nm, "_fail_cnt"}, 32'(fcnt_s[k]), 32'(v.fcnt));
      chk({v.nm, "_first_fail"}, 32'(ff_s[k]), 32'(v.ff));
      @(posedge clk); #1;
      chk({v.nm, "_done_one_cycle"}, 32'(done_s[k]), 32'd0);
      chk({v.nm, "_sum_held"}, 32'(sum_s[k]), 32'(v.sume));
      chk({v.nm, "_pass_held"}, 32'(pass_s[k]), 32'(v.pass));
   endtask

   initial begin
      int dn;
      //          inst mode et  lat pass max sum  fcnt ff
      tbl[0] = '{0, 2'd0, 4'd0,  17, 1'b1, 4'd0,  8'd0,   5'd0, 4'hF, "t1_exact"};
      tbl[1] = '{0, 2'd1, 4'd5,  17, 1'b0, 4'd9,  8'd36,  5'd3, 4'd11, "t2_zero"};
      tbl[2] = '{1, 2'd1, 4'd5,  19, 1'b0, 4'd9,  8'd36,  5'd3, 4'd11, "t3_lat2_zero"};
      tbl[3] = '{1, 2'd0, 4'd0,  19, 1'b1, 4'd0,  8'd0,   5'd0, 4'hF, "lat2_exact"};
      tbl[4] = '{2, 2'd1, 4'd5,  13, 1'b0, 4'd6,  8'd18,  5'd1, 4'd11, "t4_stop"};
      tbl[5] = '{0, 2'd2, 4'd15, 17, 1'b1, 4'd15, 8'd204, 5'd0, 4'hF, "ones_et_eq_max"};
      tbl[6] = '{0, 2'd2, 4'd14, 17, 1'b0, 4'd15, 8'd204, 5'd7, 4'd0, "ones_et_below"};
      tbl[7] = '{2, 2'd2, 4'd15, 17, 1'b1, 4'd15, 8'd204, 5'd0, 4'hF, "stop_no_fail"};

      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start_s[k] = 1'b0;
         abort_s[k] = 1'b0;
         et_s[k]    = 4'd0;
         mode_s[k]  = 2'd0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_stim_%0d", k), 32'(stim_s[k]), 32'd0);
         chk($sformatf("reset_busy_%0d", k), 32'(busy_s[k]), 32'd0);
         chk($sformatf("reset_ff_%0d", k), 32'(ff_s[k]), 32'hF);
         chk($sformatf("reset_sum_%0d", k), 32'(sum_s[k]), 32'd0);
      end

      for (int i = 0; i < 8; i++) run_sweep(tbl[i]);

      // Reset in mid-sweep clears everything in the following cycle.
      kick(0, 2'd1, 4'd5);
      wait_stim(0, 4'd7);
      chk("t5_sum_before_rst", 32'(sum_s[0]), 32'd3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_stim", 32'(stim_s[0]), 32'd0);
      chk("t5_busy", 32'(busy_s[0]), 32'd0);
      chk("t5_done", 32'(done_s[0]), 32'd0);
      chk("t5_pass", 32'(pass_s[0]), 32'd0);
      chk("t5_max", 32'(max_s[0]), 32'd0);
      chk("t5_sum", 32'(sum_s[0]), 32'd0);
      chk("t5_fcnt", 32'(fcnt_s[0]), 32'd0);
      chk("t5_ff", 32'(ff_s[0]), 32'hF);
      run_sweep(tbl[0]);

      // Start while busy is ignored; abort leaves partial accumulators.
      kick(0, 2'd2, 4'd5);
      wait_stim(0, 4'd2);
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      chk("t6_no_restart_stim", 32'(stim_s[0]), 32'd3);
      chk("t6_no_restart_busy", 32'(busy_s[0]), 32'd1);
      wait_stim(0, 4'd4);
      abort_s[0] = 1'b1;
      @(posedge clk); #1;
      abort_s[0] = 1'b0;
      chk("t6_abort_busy", 32'(busy_s[0]), 32'd0);
      chk("t6_abort_done", 32'(done_s[0]), 32'd0);
      chk("t6_abort_pass", 32'(pass_s[0]), 32'd0);
      chk("t6_abort_sum", 32'(sum_s[0]), 32'd75);
      dn = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done_s[0]) dn++;
      end
      chk("t6_no_done_pulse", 32'(dn), 32'd0);
      chk("t6_sum_holds", 32'(sum_s[0]), 32'd75);

      // Abort together with start in IDLE: start is ignored.
      @(negedge clk);
      start_s[0] = 1'b1;
      abort_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      abort_s[0] = 1'b0;
      chk("abort_start_busy", 32'(busy_s[0]), 32'd0);
      chk("abort_start_sum", 32'(sum_s[0]), 32'd75);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
